fcnn_sequencer: RTL and testbench
=================================

Name: fcnn_sequencer

Overview:
Top-level controller for the 784-30-10 fully connected inference datapath. On a start request it latches the input image, then steps the two matrix-multiply stages and two neuron-layer stages in order, holding each stage enable for that stage's fixed latency. It then scans the 10 output activations serially to find the winning class, and reports the class with a done pulse. It sits between the host/test harness and the network datapath, and is the only block that drives the stage enables.

Parameters:
DATA_WIDTH, 8, width of each output activation
N_OUT, 10, number of output neurons scanned by argmax (2..16)
IDX_W, 4, width of class index, must satisfy 2**IDX_W >= N_OUT
MULT0_LAT, 2, cycles stage matrixMult0 needs (>=1)
ACT0_LAT, 1, cycles hidden neuron layer needs (>=1)
MULT1_LAT, 2, cycles matrixMult1 needs (>=1)
ACT1_LAT, 1, cycles output neuron layer needs (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request one inference; sampled only in IDLE
abort  in  1  synchronous cancel of the current inference
out_data  in  N_OUT x DATA_WIDTH  output activations from the output layer
capture_en  out  1  one-cycle strobe: input image register loads iData
stage_en  out  4  one-hot enable: [0] mult0, [1] act0, [2] mult1, [3] act1
busy  out  1  high from the cycle after start is accepted through DONE
done  out  1  one-cycle pulse: result valid this cycle
result_valid  out  1  level: class_idx/max_value hold a completed result
class_idx  out  IDX_W  index of the largest out_data element
max_value  out  DATA_WIDTH  value of that element

Behaviour:
- Reset (rst=1 at an edge): state IDLE, all outputs 0, internal counters 0. Reset wins over every other input.
- States and the order they run in: IDLE -> CAPTURE (1 cycle) -> M0 (MULT0_LAT) -> A0 (ACT0_LAT) -> M1 (MULT1_LAT) -> A1 (ACT1_LAT) -> SCAN (N_OUT) -> DONE (1 cycle) -> IDLE.
- The state timer is a down-counter loaded with (latency-1) on entry to each state. The state advances when the counter reaches 0.
- IDLE: start=1 moves to CAPTURE on the next edge, and the same edge clears result_valid. start while not in IDLE is ignored (no queueing).
- CAPTURE: capture_en=1 and busy=1.
- Stage enables:
  - stage_en is one-hot while the FSM is in M0/A0/M1/A1, and 0 in every other state.
  - There is no overlap and no gap: the last cycle of one stage is immediately followed by the first cycle of the next.
- SCAN:
  - Scan index i runs 0..N_OUT-1, one element per cycle.
  - Comparison is unsigned.
  - At i=0 the running max and index are loaded unconditionally.
  - At i>0 they update only if out_data[i] > running max (strict), so on ties the lowest index wins.
  - out_data must stay stable throughout SCAN; the datapath holds its output once act1 is deasserted.
- DONE:
  - done=1 and result_valid goes to 1.
  - class_idx/max_value take the final scan result in this same cycle.
  - They then hold until the next reset or the next result.
- Latency: with start accepted at edge 0, done is high in cycle 2+MULT0_LAT+ACT0_LAT+MULT1_LAT+ACT1_LAT+N_OUT. With defaults that is cycle 18. busy is high in cycles 1..18.
- Back-to-back: start held high in DONE is ignored. start sampled in the following IDLE cycle is accepted, giving a minimum period of 19 cycles with defaults.
- abort:
  - In any non-IDLE state: next state IDLE, all enables and busy drop on that edge, no done pulse.
  - result_valid stays 0 if it was cleared by the aborted start.
  - abort in IDLE has no effect. If abort and start are both high in IDLE, start is accepted (abort is only meaningful when busy).
  - If abort and rst are both high, reset applies.
- Reset mid-operation behaves exactly as power-on reset; no partial result is reported.
- class_idx and max_value change only on the DONE edge and on reset.

Test Plan:
- Default params, start pulse, out_data = {5,9,3,200,7,0,1,2,4,6} -> capture_en in cycle 1; stage_en 0001 in cycles 2-3, 0010 in 4, 0100 in 5-6, 1000 in 7; done in cycle 18; class_idx=3, max_value=200, result_valid=1.
- Ties: out_data all 8'h40, with 8'hFF at indices 2 and 7 -> class_idx=2, max_value=255. All zeros -> class_idx=0, max_value=0.
- start held high continuously for 60 cycles -> three done pulses at cycles 18, 37, 56; start ignored while busy.
- abort asserted in cycle 5 (M1) -> busy=0 and stage_en=0 from cycle 6; no done; result_valid=0; a new start afterwards completes normally in 18 cycles.
- rst asserted in cycle 10 (SCAN) together with start -> all outputs 0 next cycle; after release, the previous class_idx is not restored (reads 0).
- MULT0_LAT=5, N_OUT=4, IDX_W=2 -> stage_en[0] high for exactly 5 cycles; done at cycle 2+5+1+2+1+4=15.

Source files
------------

// File: rtl/fcnn_sequencer.sv
// fcnn_sequencer: top-level controller for the 784-30-10 fully connected
// inference datapath. Latches the input image, steps the four datapath
// stages for their fixed latencies, then scans the output activations to
// find the winning class.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for start; result registers hold the last answer
// S_CAPTURE | one cycle, input image register loads iData
// S_M0      | matrixMult0 enabled for MULT0_LAT cycles
// S_A0      | hidden neuron layer enabled for ACT0_LAT cycles
// S_M1      | matrixMult1 enabled for MULT1_LAT cycles
// S_A1      | output neuron layer enabled for ACT1_LAT cycles
// S_SCAN    | serial argmax over N_OUT activations, one per cycle
// S_DONE    | one cycle, done pulse, result registers just updated

module fcnn_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int N_OUT      = 10,
   parameter int IDX_W      = 4,
   parameter int MULT0_LAT  = 2,
   parameter int ACT0_LAT   = 1,
   parameter int MULT1_LAT  = 2,
   parameter int ACT1_LAT   = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        abort,
   input  logic [N_OUT*DATA_WIDTH-1:0] out_data,
   output logic                        capture_en,
   output logic [3:0]                  stage_en,
   output logic                        busy,
   output logic                        done,
   output logic                        result_valid,
   output logic [IDX_W-1:0]            class_idx,
   output logic [DATA_WIDTH-1:0]       max_value
);

   localparam int MAX_M   = (MULT0_LAT > MULT1_LAT) ? MULT0_LAT : MULT1_LAT;
   localparam int MAX_A   = (ACT0_LAT > ACT1_LAT) ? ACT0_LAT : ACT1_LAT;
   localparam int MAX_S   = (MAX_M > MAX_A) ? MAX_M : MAX_A;
   localparam int MAX_LAT = (MAX_S > N_OUT) ? MAX_S : N_OUT;
   // Timer only ever holds latency-1, and N_OUT >= 2 keeps this >= 1.
   localparam int TMR_W   = $clog2(MAX_LAT);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CAPTURE = 3'd1,
      S_M0      = 3'd2,
      S_A0      = 3'd3,
      S_M1      = 3'd4,
      S_A1      = 3'd5,
      S_SCAN    = 3'd6,
      S_DONE    = 3'd7
   } state_t;

   state_t                state_q, state_d;
   logic [TMR_W-1:0]      timer_q, timer_d;
   logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
   logic [DATA_WIDTH-1:0] max_run_q, max_run_d;
   logic [IDX_W-1:0]      idx_run_q, idx_run_d;
   logic                  capture_en_q, capture_en_d;
   logic [3:0]            stage_en_q, stage_en_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  result_valid_q, result_valid_d;
   logic [IDX_W-1:0]      class_idx_q, class_idx_d;
   logic [DATA_WIDTH-1:0] max_value_q, max_value_d;

   logic [DATA_WIDTH-1:0] elem;
   logic                  take;
   logic [DATA_WIDTH-1:0] cand_max;
   logic [IDX_W-1:0]      cand_idx;
   logic                  last;

   // Timer reload value for the state being entered.
   function automatic logic [TMR_W-1:0] load_val(input state_t s);
      logic [TMR_W-1:0] v;
      case (s)
         S_M0:    v = TMR_W'(MULT0_LAT - 1);
         S_A0:    v = TMR_W'(ACT0_LAT - 1);
         S_M1:    v = TMR_W'(MULT1_LAT - 1);
         S_A1:    v = TMR_W'(ACT1_LAT - 1);
         S_SCAN:  v = TMR_W'(N_OUT - 1);
         default: v = '0;
      endcase
      return v;
   endfunction

   // Select the activation currently under the scan index.
   always_comb begin
      elem = '0;
      for (int k = 0; k < N_OUT; k++) begin
         if (scan_idx_q == IDX_W'(k)) begin
            elem = out_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Running argmax step: first element loads, later ones must be strictly larger.
   always_comb begin
      take     = (scan_idx_q == '0) || (elem > max_run_q);
      cand_max = take ? elem : max_run_q;
      cand_idx = take ? scan_idx_q : idx_run_q;
   end

   // Next-state, timer, scan and registered-output computation.
   always_comb begin
      state_d        = state_q;
      timer_d        = timer_q;
      scan_idx_d     = scan_idx_q;
      max_run_d      = max_run_q;
      idx_run_d      = idx_run_q;
      class_idx_d    = class_idx_q;
      max_value_d    = max_value_q;
      result_valid_d = result_valid_q;
      last           = (timer_q == '0);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d        = S_CAPTURE;
               result_valid_d = 1'b0;
            end
         end
         S_CAPTURE: state_d = S_M0;
         S_M0:      if (last) state_d = S_A0;
         S_A0:      if (last) state_d = S_M1;
         S_M1:      if (last) state_d = S_A1;
         S_A1:      if (last) state_d = S_SCAN;
         S_SCAN: begin
            max_run_d  = cand_max;
            idx_run_d  = cand_idx;
            scan_idx_d = scan_idx_q + IDX_W'(1);
            if (last) begin
               state_d        = S_DONE;
               class_idx_d    = cand_idx;
               max_value_d    = cand_max;
               result_valid_d = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Abort discards the run, including a result that was about to land.
      if (abort && (state_q != S_IDLE)) begin
         state_d        = S_IDLE;
         class_idx_d    = class_idx_q;
         max_value_d    = max_value_q;
         result_valid_d = result_valid_q;
      end

      if (state_d != state_q) begin
         timer_d    = load_val(state_d);
         scan_idx_d = '0;
      end else if (!last) begin
         timer_d = timer_q - TMR_W'(1);
      end

      // Outputs are decoded from the next state so they are registered.
      capture_en_d = (state_d == S_CAPTURE);
      busy_d       = (state_d != S_IDLE);
      done_d       = (state_d == S_DONE);
      case (state_d)
         S_M0:    stage_en_d = 4'b0001;
         S_A0:    stage_en_d = 4'b0010;
         S_M1:    stage_en_d = 4'b0100;
         S_A1:    stage_en_d = 4'b1000;
         default: stage_en_d = 4'b0000;
      endcase
   end

   // State and output registers; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         timer_q        <= '0;
         scan_idx_q     <= '0;
         max_run_q      <= '0;
         idx_run_q      <= '0;
         capture_en_q   <= 1'b0;
         stage_en_q     <= 4'b0000;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         result_valid_q <= 1'b0;
         class_idx_q    <= '0;
         max_value_q    <= '0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         scan_idx_q     <= scan_idx_d;
         max_run_q      <= max_run_d;
         idx_run_q      <= idx_run_d;
         capture_en_q   <= capture_en_d;
         stage_en_q     <= stage_en_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         result_valid_q <= result_valid_d;
         class_idx_q    <= class_idx_d;
         max_value_q    <= max_value_d;
      end
   end

   assign capture_en   = capture_en_q;
   assign stage_en     = stage_en_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign result_valid = result_valid_q;
   assign class_idx    = class_idx_q;
   assign max_value    = max_value_q;

endmodule

// File: tb/tb_fcnn_sequencer.sv
// Testbench for fcnn_sequencer: a default-parameter instance and a
// MULT0_LAT=5 / N_OUT=4 instance, each checked every cycle against a
// timeline model, plus literal expectations from hand-worked scenarios.

module tb_fcnn_sequencer;

   localparam int LM0 [2] = '{2, 5};
   localparam int LA0 [2] = '{1, 1};
   localparam int LM1 [2] = '{2, 2};
   localparam int LA1 [2] = '{1, 1};
   localparam int LN  [2] = '{10, 4};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, abort, start2, abort2;
   logic [7:0]  od1 [10];
   logic [7:0]  od2 [4];
   logic [79:0] out_data1;
   logic [31:0] out_data2;

   for (genvar g = 0; g < 10; g++) begin : g_pack1
      assign out_data1[g*8 +: 8] = od1[g];
   end
   for (genvar g = 0; g < 4; g++) begin : g_pack2
      assign out_data2[g*8 +: 8] = od2[g];
   end

   logic       cap1, busy1, done1, rv1;
   logic [3:0] stg1, cls1;
   logic [7:0] max1;
   logic       cap2, busy2, done2, rv2;
   logic [3:0] stg2;
   logic [1:0] cls2;
   logic [7:0] max2;

   fcnn_sequencer dut1 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .out_data(out_data1),
      .capture_en(cap1), .stage_en(stg1), .busy(busy1), .done(done1),
      .result_valid(rv1), .class_idx(cls1), .max_value(max1)
   );

   fcnn_sequencer #(
      .DATA_WIDTH(8), .N_OUT(4), .IDX_W(2),
      .MULT0_LAT(5), .ACT0_LAT(1), .MULT1_LAT(2), .ACT1_LAT(1)
   ) dut2 (
      .clk(clk), .rst(rst), .start(start2), .abort(abort2), .out_data(out_data2),
      .capture_en(cap2), .stage_en(stg2), .busy(busy2), .done(done2),
      .result_valid(rv2), .class_idx(cls2), .max_value(max2)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A run is a timeline: cycle k=1 is capture, stages follow back to back,
   // then N_OUT scan cycles, then done at k=total.
   bit m_act [2];
   int m_k   [2];
   bit m_rv  [2];
   int m_cls [2];
   int m_max [2];

   function automatic int total(input int d);
      return 2 + LM0[d] + LA0[d] + LM1[d] + LA1[d] + LN[d];
   endfunction

   function automatic int el(input int d, input int i);
      if (d == 0) return int'(od1[i]);
      return int'(od2[i]);
   endfunction

   function automatic int exp_stage(input int d, input int k);
      int b1, b2, b3, b4;
      b1 = 2 + LM0[d];
      b2 = b1 + LA0[d];
      b3 = b2 + LM1[d];
      b4 = b3 + LA1[d];
      if (k >= 2 && k < b1) return 1;
      if (k >= b1 && k < b2) return 2;
      if (k >= b2 && k < b3) return 4;
      if (k >= b3 && k < b4) return 8;
      return 0;
   endfunction

   always @(posedge clk) begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
         bit st, ab;
         st = (d == 0) ? start : start2;
         ab = (d == 0) ? abort : abort2;
         if (rst) begin
            m_act[d] = 1'b0; m_k[d] = 0; m_rv[d] = 1'b0; m_cls[d] = 0; m_max[d] = 0;
         end else if (m_act[d]) begin
            if (ab || m_k[d] == total(d)) begin
               m_act[d] = 1'b0;
            end else begin
               m_k[d]++;
               if (m_k[d] == total(d)) begin
                  int best;
                  best = 0;
                  for (int i = 1; i < LN[d]; i++) if (el(d, i) > el(d, best)) best = i;
                  m_rv[d]  = 1'b1;
                  m_cls[d] = best;
                  m_max[d] = el(d, best);
               end
            end
         end else if (st) begin
            m_act[d] = 1'b1; m_k[d] = 1; m_rv[d] = 1'b0;
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         int k0, k1;
         k0 = m_act[0] ? m_k[0] : 0;
         k1 = m_act[1] ? m_k[1] : 0;
         chk("d1_capture_en", int'(cap1), int'(k0 == 1));
         chk("d1_stage_en", int'(stg1), exp_stage(0, k0));
         chk("d1_busy", int'(busy1), int'(m_act[0]));
         chk("d1_done", int'(done1), int'(m_act[0] && k0 == total(0)));
         chk("d1_result_valid", int'(rv1), int'(m_rv[0]));
         chk("d1_class_idx", int'(cls1), m_cls[0]);
         chk("d1_max_value", int'(max1), m_max[0]);
         chk("d2_capture_en", int'(cap2), int'(k1 == 1));
         chk("d2_stage_en", int'(stg2), exp_stage(1, k1));
         chk("d2_busy", int'(busy2), int'(m_act[1]));
         chk("d2_done", int'(done2), int'(m_act[1] && k1 == total(1)));
         chk("d2_result_valid", int'(rv2), int'(m_rv[1]));
         chk("d2_class_idx", int'(cls2), m_cls[1]);
         chk("d2_max_value", int'(max2), m_max[1]);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called in cycle 1 of a run; returns the cycle number where done is seen, -1 on timeout.
   task automatic wait_done(input int limit, output int r);
      r = -1;
      for (int i = 1; i <= limit; i++) begin
         if (done1) begin
            r = i;
            break;
         end
         tick(1);
      end
   endtask

   task automatic load_img1();
      int v [10];
      v = '{5, 9, 3, 200, 7, 0, 1, 2, 4, 6};
      for (int i = 0; i < 10; i++) od1[i] = 8'(v[i]);
   endtask

   task automatic wait_idle1();
      for (int i = 0; i < 40; i++) begin
         if (!busy1) break;
         tick(1);
      end
      chk("idle_reached", int'(busy1), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int r, cnt, dpos;
      int dones [$];
      rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
      for (int i = 0; i < 10; i++) od1[i] = 8'h00;
      for (int i = 0; i < 4; i++) od2[i] = 8'h00;
      tick(2);
      chk_en = 1'b1;
      chk("rst_busy", int'(busy1), 0);
      chk("rst_class_idx", int'(cls1), 0);
      rst = 1'b0;
      tick(1);

      // Basic run with the reference image.
      load_img1();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("t1_capture_c1", int'(cap1), 1);
      tick(1);
      chk("t1_stage_c2", int'(stg1), 1);
      tick(2);
      chk("t1_stage_c4", int'(stg1), 2);
      tick(1);
      chk("t1_stage_c5", int'(stg1), 4);
      tick(2);
      chk("t1_stage_c7", int'(stg1), 8);
      tick(10);
      chk("t1_done_c17", int'(done1), 0);
      tick(1);
      chk("t1_done_c18", int'(done1), 1);
      chk("t1_class_idx", int'(cls1), 3);
      chk("t1_max_value", int'(max1), 200);
      chk("t1_result_valid", int'(rv1), 1);
      tick(1);
      chk("t1_busy_c19", int'(busy1), 0);
      tick(1);

      // Ties: lowest index wins.
      for (int i = 0; i < 10; i++) od1[i] = 8'h40;
      od1[2] = 8'hFF;
      od1[7] = 8'hFF;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      wait_done(40, r);
      chk("tie_done_cycle", r, 18);
      chk("tie_class_idx", int'(cls1), 2);
      chk("tie_max_value", int'(max1), 255);
      tick(2);

      // All zeros.
      for (int i = 0; i < 10; i++) od1[i] = 8'h00;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      wait_done(40, r);
      chk("zero_done_cycle", r, 18);
      chk("zero_class_idx", int'(cls1), 0);
      chk("zero_max_value", int'(max1), 0);
      tick(2);

      // start held for 60 cycles.
      load_img1();
      start = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         tick(1);
         if (done1) dones.push_back(c);
      end
      start = 1'b0;
      chk("b2b_done_count", dones.size(), 3);
      if (dones.size() == 3) begin
         chk("b2b_done0", dones[0], 18);
         chk("b2b_done1", dones[1], 37);
         chk("b2b_done2", dones[2], 56);
      end
      wait_idle1();
      tick(2);

      // Abort in M1, then a clean rerun.
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(4);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("abort_busy_c6", int'(busy1), 0);
      chk("abort_stage_c6", int'(stg1), 0);
      chk("abort_rv_c6", int'(rv1), 0);
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         if (done1) cnt++;
         tick(1);
      end
      chk("abort_no_done", cnt, 0);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      wait_done(40, r);
      chk("rerun_done_cycle", r, 18);
      chk("rerun_class_idx", int'(cls1), 3);
      tick(2);

      // Reset in SCAN together with start.
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(9);
      rst = 1'b1;
      start = 1'b1;
      tick(1);
      chk("rst_mid_busy", int'(busy1), 0);
      chk("rst_mid_class", int'(cls1), 0);
      chk("rst_mid_max", int'(max1), 0);
      chk("rst_mid_stage", int'(stg1), 0);
      rst = 1'b0;
      start = 1'b0;
      tick(1);
      chk("rst_after_class", int'(cls1), 0);
      chk("rst_after_rv", int'(rv1), 0);
      tick(2);

      // Second instance: MULT0_LAT=5, N_OUT=4.
      od2[0] = 8'd10; od2[1] = 8'd50; od2[2] = 8'd50; od2[3] = 8'd3;
      start2 = 1'b1;
      tick(1);
      start2 = 1'b0;
      cnt = 0;
      dpos = -1;
      for (int c = 1; c <= 30; c++) begin
         if (stg2[0]) cnt++;
         if (done2 && dpos < 0) dpos = c;
         tick(1);
      end
      chk("p2_mult0_cycles", cnt, 5);
      chk("p2_done_cycle", dpos, 15);
      chk("p2_class_idx", int'(cls2), 1);
      chk("p2_max_value", int'(max2), 50);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
